// File: rtl/apu_shared_rr_dispatcher_if.sv
// Bundle of core-side and unit-side signals around the shared APU dispatcher.
// The slave view belongs to the dispatcher; the master view to the cores and the unit.
interface apu_shared_rr_dispatcher_if #(
    parameter int NB_CORES   = 4,
    parameter int DATA_WIDTH = 32,
    parameter int NARGS      = 3,
    parameter int WOP        = 4,
    parameter int NDSFLAGS   = 11,
    parameter int NUSFLAGS   = 5,
    parameter int CNT_WIDTH  = 16
);
    logic [NB_CORES-1:0]                  core_req_i;
    logic [NB_CORES-1:0]                  core_gnt_o;
    logic [NB_CORES*WOP-1:0]              core_op_i;
    logic [NB_CORES*NARGS*DATA_WIDTH-1:0] core_operands_i;
    logic [NB_CORES*NDSFLAGS-1:0]         core_flags_i;
    logic [NB_CORES-1:0]                  core_rvalid_o;
    logic [DATA_WIDTH-1:0]                core_result_o;
    logic [NUSFLAGS-1:0]                  core_rflags_o;
    logic                                 unit_en_o;
    logic [WOP-1:0]                       unit_op_o;
    logic [NARGS*DATA_WIDTH-1:0]          unit_operands_o;
    logic [NDSFLAGS-1:0]                  unit_flags_o;
    logic [DATA_WIDTH-1:0]                unit_result_i;
    logic [NUSFLAGS-1:0]                  unit_rflags_i;
    logic                                 cnt_clear_i;
    logic [CNT_WIDTH-1:0]                 contention_o;

    modport slave (
        input  core_req_i, core_op_i, core_operands_i, core_flags_i,
               unit_result_i, unit_rflags_i, cnt_clear_i,
        output core_gnt_o, core_rvalid_o, core_result_o, core_rflags_o,
               unit_en_o, unit_op_o, unit_operands_o, unit_flags_o, contention_o
    );

    modport master (
        output core_req_i, core_op_i, core_operands_i, core_flags_i,
               unit_result_i, unit_rflags_i, cnt_clear_i,
        input  core_gnt_o, core_rvalid_o, core_result_o, core_rflags_o,
               unit_en_o, unit_op_o, unit_operands_o, unit_flags_o, contention_o
    );
endinterface

// File: rtl/apu_shared_rr_dispatcher.sv
// Round-robin sharing of one fixed-latency APU unit between NB_CORES cores,
// with a tag pipe that routes each result back to its issuing core.
module apu_shared_rr_dispatcher #(
    parameter int NB_CORES   = 4,
    parameter int DATA_WIDTH = 32,
    parameter int NARGS      = 3,
    parameter int WOP        = 4,
    parameter int NDSFLAGS   = 11,
    parameter int NUSFLAGS   = 5,
    parameter int PIPE_REGS  = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    apu_shared_rr_dispatcher_if.slave    bus
);
    localparam int PW = (NB_CORES > 1) ? $clog2(NB_CORES) : 1;

    logic [PW-1:0]               rr_ptr;
    logic [PW-1:0]               gnt_idx;
    logic [PW-1:0]               cand;
    logic                        gnt_any;
    logic [NB_CORES-1:0]         gnt;
    logic [WOP-1:0]              op_mux;
    logic [NARGS*DATA_WIDTH-1:0] operands_mux;
    logic [NDSFLAGS-1:0]         flags_mux;
    logic                        multi_req;
    logic [CNT_WIDTH-1:0]        cnt;
    logic                        out_valid;
    logic [PW-1:0]               out_tag;
    logic [NB_CORES-1:0]         rvalid;

    // Scan starting at rr_ptr; the first requester found wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        cand    = '0;
        for (int i = 0; i < NB_CORES; i++) begin
            cand = PW'((int'(rr_ptr) + i) % NB_CORES);
            if (!gnt_any && bus.core_req_i[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
        if (gnt_any) gnt[gnt_idx] = 1'b1;
    end

    always_comb begin
        op_mux       = '0;
        operands_mux = '0;
        flags_mux    = '0;
        for (int k = 0; k < NB_CORES; k++) begin
            if (gnt[k]) begin
                op_mux       = bus.core_op_i[k*WOP +: WOP];
                operands_mux = bus.core_operands_i[k*NARGS*DATA_WIDTH +: NARGS*DATA_WIDTH];
                flags_mux    = bus.core_flags_i[k*NDSFLAGS +: NDSFLAGS];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr <= '0;
        end else if (gnt_any) begin
            rr_ptr <= (gnt_idx == PW'(NB_CORES - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // x & (x-1) is non-zero exactly when two or more request bits are set.
    assign multi_req = |(bus.core_req_i & (bus.core_req_i - 1'b1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt <= '0;
        end else if (bus.cnt_clear_i) begin
            cnt <= '0;
        end else if (multi_req && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

    generate
        if (PIPE_REGS > 0) begin : g_pipe
            logic [PIPE_REGS-1:0]         pipe_valid;
            logic [PIPE_REGS-1:0][PW-1:0] pipe_tag;
            logic [PIPE_REGS:0]           valid_in;
            logic [PIPE_REGS:0][PW-1:0]   tag_in;

            // Stage 0 takes the new issue; the concatenation shifts every stage by one.
            assign valid_in = {pipe_valid, gnt_any};
            assign tag_in   = {pipe_tag, gnt_idx};

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    pipe_valid <= '0;
                    pipe_tag   <= '0;
                end else begin
                    pipe_valid <= valid_in[PIPE_REGS-1:0];
                    pipe_tag   <= tag_in[PIPE_REGS-1:0];
                end
            end

            assign out_valid = pipe_valid[PIPE_REGS-1];
            assign out_tag   = pipe_tag[PIPE_REGS-1];
        end else begin : g_comb
            assign out_valid = gnt_any;
            assign out_tag   = gnt_idx;
        end
    endgenerate

    always_comb begin
        rvalid = '0;
        if (out_valid) rvalid[out_tag] = 1'b1;
    end

    assign bus.core_gnt_o      = gnt;
    assign bus.unit_en_o       = |bus.core_req_i;
    assign bus.unit_op_o       = op_mux;
    assign bus.unit_operands_o = operands_mux;
    assign bus.unit_flags_o    = flags_mux;
    assign bus.core_rvalid_o   = rvalid;
    assign bus.core_result_o   = out_valid ? bus.unit_result_i : '0;
    assign bus.core_rflags_o   = out_valid ? bus.unit_rflags_i : '0;
    assign bus.contention_o    = cnt;
endmodule

// File: tb/tb_apu_shared_rr_dispatcher.sv
// Directed bench for the shared APU dispatcher: three instances cover latency 1
// (with a 4-bit counter for saturation), latency 3 with mid-flight reset, and latency 0.
module tb_apu_shared_rr_dispatcher;
    localparam int NB  = 4;
    localparam int DW  = 32;
    localparam int NA  = 3;
    localparam int WOP = 4;
    localparam int NDS = 11;
    localparam int NUS = 5;

    logic clk = 1'b0;
    logic rst_n;
    logic rst_nb;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    apu_shared_rr_dispatcher_if #(.CNT_WIDTH(4))  ifa ();
    apu_shared_rr_dispatcher_if #(.CNT_WIDTH(16)) ifb ();
    apu_shared_rr_dispatcher_if #(.CNT_WIDTH(16)) ifc ();

    apu_shared_rr_dispatcher #(.PIPE_REGS(1), .CNT_WIDTH(4)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .bus(ifa)
    );
    apu_shared_rr_dispatcher #(.PIPE_REGS(3), .CNT_WIDTH(16)) dut_b (
        .clk_i(clk), .rst_ni(rst_nb), .bus(ifb)
    );
    apu_shared_rr_dispatcher #(.PIPE_REGS(0), .CNT_WIDTH(16)) dut_c (
        .clk_i(clk), .rst_ni(rst_n), .bus(ifc)
    );

    function automatic logic [31:0] opnd_word(int k, int a);
        return 32'hA000_0000 | (k << 8) | a;
    endfunction

    function automatic logic [127:0] exp_operands(int k);
        logic [127:0] r;
        r = '0;
        for (int a = 0; a < NA; a++) r[a*DW +: DW] = opnd_word(k, a);
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Drive one cycle of stimulus on the selected instance and stop at the following negedge.
    task automatic applyStimulus(input int sel, input logic [3:0] req, input logic clr,
                                 input logic [31:0] res, input logic [4:0] rfl);
        @(posedge clk);
        #1;
        case (sel)
            0: begin ifa.core_req_i = req; ifa.cnt_clear_i = clr; ifa.unit_result_i = res; ifa.unit_rflags_i = rfl; end
            1: begin ifb.core_req_i = req; ifb.cnt_clear_i = clr; ifb.unit_result_i = res; ifb.unit_rflags_i = rfl; end
            default: begin ifc.core_req_i = req; ifc.cnt_clear_i = clr; ifc.unit_result_i = res; ifc.unit_rflags_i = rfl; end
        endcase
        @(negedge clk);
    endtask

    initial begin
        logic [NB*WOP-1:0]    op_vec;
        logic [NB*NA*DW-1:0]  opr_vec;
        logic [NB*NDS-1:0]    flg_vec;
        logic [3:0]           req;

        for (int k = 0; k < NB; k++) begin
            op_vec[k*WOP +: WOP] = WOP'(k + 1);
            flg_vec[k*NDS +: NDS] = NDS'(11'h100 + k);
            for (int a = 0; a < NA; a++) opr_vec[(k*NA + a)*DW +: DW] = opnd_word(k, a);
        end

        rst_n  = 1'b0;
        rst_nb = 1'b0;
        ifa.core_req_i = '0; ifa.cnt_clear_i = 1'b0; ifa.unit_result_i = '0; ifa.unit_rflags_i = '0;
        ifb.core_req_i = '0; ifb.cnt_clear_i = 1'b0; ifb.unit_result_i = '0; ifb.unit_rflags_i = '0;
        ifc.core_req_i = '0; ifc.cnt_clear_i = 1'b0; ifc.unit_result_i = '0; ifc.unit_rflags_i = '0;
        ifa.core_op_i = op_vec; ifa.core_operands_i = opr_vec; ifa.core_flags_i = flg_vec;
        ifb.core_op_i = op_vec; ifb.core_operands_i = opr_vec; ifb.core_flags_i = flg_vec;
        ifc.core_op_i = op_vec; ifc.core_operands_i = opr_vec; ifc.core_flags_i = flg_vec;

        #2;
        checkOutput("rst_gnt", ifa.core_gnt_o, 0);
        checkOutput("rst_en", ifa.unit_en_o, 0);
        checkOutput("rst_rvalid", ifa.core_rvalid_o, 0);
        checkOutput("rst_cnt", ifa.contention_o, 0);
        checkOutput("rst_b_rvalid", ifb.core_rvalid_o, 0);
        #10;
        rst_n  = 1'b1;
        rst_nb = 1'b1;

        // Single request from core 2 at latency 1.
        applyStimulus(0, 4'b0100, 1'b0, 32'hCAFE_0001, 5'h11);
        checkOutput("t1_gnt", ifa.core_gnt_o, 4'b0100);
        checkOutput("t1_en", ifa.unit_en_o, 1);
        checkOutput("t1_op", ifa.unit_op_o, 3);
        checkOutput("t1_operands", ifa.unit_operands_o, exp_operands(2));
        checkOutput("t1_flags", ifa.unit_flags_o, 11'h102);
        checkOutput("t1_rvalid0", ifa.core_rvalid_o, 0);
        checkOutput("t1_result0", ifa.core_result_o, 0);
        applyStimulus(0, 4'b0000, 1'b0, 32'hCAFE_0001, 5'h11);
        checkOutput("t1_rvalid1", ifa.core_rvalid_o, 4'b0100);
        checkOutput("t1_result1", ifa.core_result_o, 32'hCAFE_0001);
        checkOutput("t1_rflags1", ifa.core_rflags_o, 5'h11);
        checkOutput("t1_idle_gnt", ifa.core_gnt_o, 0);
        checkOutput("t1_idle_en", ifa.unit_en_o, 0);
        checkOutput("t1_idle_op", ifa.unit_op_o, 0);
        checkOutput("t1_idle_operands", ifa.unit_operands_o, 0);
        applyStimulus(0, 4'b0000, 1'b0, 32'h0000_DEAD, 5'h1F);
        checkOutput("t1_rvalid2", ifa.core_rvalid_o, 0);
        checkOutput("t1_result2", ifa.core_result_o, 0);
        checkOutput("t1_rflags2", ifa.core_rflags_o, 0);

        // rr_ptr is now 3: wrap from core 3 to core 0, then confirm pointer moved to 1.
        applyStimulus(0, 4'b1001, 1'b0, 32'h0, 5'h0);
        checkOutput("t3_gnt_a", ifa.core_gnt_o, 4'b1000);
        checkOutput("t3_op_a", ifa.unit_op_o, 4);
        applyStimulus(0, 4'b1001, 1'b0, 32'h0, 5'h0);
        checkOutput("t3_gnt_b", ifa.core_gnt_o, 4'b0001);
        checkOutput("t3_rvalid_b", ifa.core_rvalid_o, 4'b1000);
        applyStimulus(0, 4'b0011, 1'b0, 32'h0, 5'h0);
        checkOutput("t3_gnt_c", ifa.core_gnt_o, 4'b0010);
        checkOutput("t3_rvalid_c", ifa.core_rvalid_o, 4'b0001);
        applyStimulus(0, 4'b0000, 1'b0, 32'h0, 5'h0);
        checkOutput("t3_rvalid_d", ifa.core_rvalid_o, 4'b0010);
        checkOutput("t3_cnt", ifa.contention_o, 3);
        applyStimulus(0, 4'b0100, 1'b0, 32'h0, 5'h0);
        checkOutput("t3_gnt_e", ifa.core_gnt_o, 4'b0100);
        applyStimulus(0, 4'b1000, 1'b1, 32'h0, 5'h0);
        checkOutput("t3_gnt_f", ifa.core_gnt_o, 4'b1000);
        applyStimulus(0, 4'b0000, 1'b0, 32'h0, 5'h0);
        checkOutput("clr_cnt", ifa.contention_o, 0);
        checkOutput("t3_rvalid_g", ifa.core_rvalid_o, 4'b1000);

        // All four request from rr_ptr=0, each dropping after its grant.
        for (int j = 0; j < 5; j++) begin
            req = (j < 4) ? 4'((4'b1111 << j) & 4'hF) : 4'b0000;
            applyStimulus(0, req, 1'b0, 32'h1000 + j, 5'(j));
            checkOutput($sformatf("t2_gnt%0d", j), ifa.core_gnt_o, (j < 4) ? (1 << j) : 0);
            checkOutput($sformatf("t2_op%0d", j), ifa.unit_op_o, (j < 4) ? (j + 1) : 0);
            checkOutput($sformatf("t2_rvalid%0d", j), ifa.core_rvalid_o, (j > 0) ? (1 << (j - 1)) : 0);
            checkOutput($sformatf("t2_result%0d", j), ifa.core_result_o, (j > 0) ? (32'h1000 + j) : 0);
        end
        checkOutput("t2_cnt", ifa.contention_o, 3);

        // Two cores held: 4-bit counter climbs from 3 and saturates at 15.
        for (int k = 1; k <= 20; k++) begin
            applyStimulus(0, 4'b0011, 1'b0, 32'h0, 5'h0);
            if (k == 12) checkOutput("t5_cnt14", ifa.contention_o, 14);
            if (k == 13) checkOutput("t5_cnt15", ifa.contention_o, 15);
        end
        checkOutput("t5_sat", ifa.contention_o, 15);
        applyStimulus(0, 4'b0011, 1'b1, 32'h0, 5'h0);
        checkOutput("t5_pre_clr", ifa.contention_o, 15);
        applyStimulus(0, 4'b0011, 1'b0, 32'h0, 5'h0);
        checkOutput("t5_clr", ifa.contention_o, 0);
        applyStimulus(0, 4'b0000, 1'b0, 32'h0, 5'h0);
        checkOutput("t5_restart", ifa.contention_o, 1);

        // Latency 3: two issues, then a one-cycle reset drops both in flight.
        applyStimulus(1, 4'b0001, 1'b0, 32'h0, 5'h0);
        checkOutput("t4_gnt0", ifb.core_gnt_o, 4'b0001);
        applyStimulus(1, 4'b0011, 1'b0, 32'h0, 5'h0);
        checkOutput("t4_gnt1", ifb.core_gnt_o, 4'b0010);
        @(posedge clk);
        #1;
        rst_nb = 1'b0;
        ifb.core_req_i = '0;
        @(negedge clk);
        checkOutput("t4_rst_cnt", ifb.contention_o, 0);
        checkOutput("t4_rst_rvalid", ifb.core_rvalid_o, 0);
        @(posedge clk);
        #1;
        rst_nb = 1'b1;
        @(negedge clk);
        checkOutput("t4_drop3", ifb.core_rvalid_o, 0);
        for (int j = 4; j < 8; j++) begin
            applyStimulus(1, 4'b0000, 1'b0, 32'h0, 5'h0);
            checkOutput($sformatf("t4_drop%0d", j), ifb.core_rvalid_o, 0);
        end
        applyStimulus(1, 4'b1111, 1'b0, 32'h0, 5'h0);
        checkOutput("t4_ptr0", ifb.core_gnt_o, 4'b0001);
        checkOutput("t4_cnt0", ifb.contention_o, 0);
        applyStimulus(1, 4'b0000, 1'b0, 32'h0, 5'h0);
        checkOutput("t4_lat1", ifb.core_rvalid_o, 0);
        applyStimulus(1, 4'b0000, 1'b0, 32'h0, 5'h0);
        checkOutput("t4_lat2", ifb.core_rvalid_o, 0);
        applyStimulus(1, 4'b0000, 1'b0, 32'h0000_0B0B, 5'h03);
        checkOutput("t4_lat3", ifb.core_rvalid_o, 4'b0001);
        checkOutput("t4_result", ifb.core_result_o, 32'h0000_0B0B);
        checkOutput("t4_cnt1", ifb.contention_o, 1);

        // Latency 0: grant and result valid in the same cycle.
        applyStimulus(2, 4'b0010, 1'b0, 32'h0000_600D, 5'h0A);
        checkOutput("t6_gnt", ifc.core_gnt_o, 4'b0010);
        checkOutput("t6_rvalid", ifc.core_rvalid_o, 4'b0010);
        checkOutput("t6_result", ifc.core_result_o, 32'h0000_600D);
        checkOutput("t6_rflags", ifc.core_rflags_o, 5'h0A);
        checkOutput("t6_op", ifc.unit_op_o, 2);
        applyStimulus(2, 4'b0000, 1'b0, 32'h0000_600D, 5'h0A);
        checkOutput("t6_idle_rvalid", ifc.core_rvalid_o, 0);
        checkOutput("t6_idle_result", ifc.core_result_o, 0);
        applyStimulus(2, 4'b0101, 1'b0, 32'h0000_7777, 5'h01);
        checkOutput("t6_gnt2", ifc.core_gnt_o, 4'b0100);
        checkOutput("t6_rvalid2", ifc.core_rvalid_o, 4'b0100);
        checkOutput("t6_result2", ifc.core_result_o, 32'h0000_7777);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
